// File: rtl/game_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | game_sequencer: Flappy Bruin round lifecycle, button edge             |
// | qualification and single-grant score/high-score arbitration.          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module game_sequencer #(
  parameter int NUM_BARS     = 3,
  parameter int SCORE_W      = 10,
  parameter int SCORE_MAX    = 999,
  parameter int READY_FRAMES = 90,
  parameter int DEATH_FRAMES = 60
) (
  input  logic                clk_25MHz,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                game_start,
  input  logic                flap,
  input  logic [NUM_BARS-1:0] collide,
  input  logic                ground_hit,
  input  logic [NUM_BARS-1:0] passed,
  input  logic [NUM_BARS-1:0] wraps,
  output logic [2:0]          state,
  output logic                scroll_en,
  output logic                physics_en,
  output logic                flap_pulse,
  output logic                lose,
  output logic                flash,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  best,
  output logic                new_best
);

  localparam int CNT_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   READY_LAST  = CNT_W'(READY_FRAMES);
  localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX_V = SCORE_W'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_BARS-1:0] credit_q, credit_d, eligible;
  logic [SCORE_W-1:0]  score_q, score_d, best_q, best_d;
  logic                start_prev_q, start_prev_d, flap_prev_q, flap_prev_d;
  logic                start_edge, flap_edge, grant_found;
  logic                scroll_q, scroll_d, physics_q, physics_d;
  logic                flap_pulse_q, flap_pulse_d, lose_q, lose_d;
  logic                flash_q, flash_d, new_best_q, new_best_d;

  always_comb begin
    start_prev_d = game_start;
    flap_prev_d  = flap;
    start_edge   = game_start & ~start_prev_q;
    flap_edge    = flap & ~flap_prev_q;
    eligible     = passed & credit_q & ~wraps;
    cnt_inc      = cnt_q + CNT_W'(1);
    state_d      = state_q;
    cnt_d        = cnt_q;
    credit_d     = credit_q;
    score_d      = score_q;
    best_d       = best_q;
    new_best_d   = new_best_q;
    flash_d      = flash_q;
    flap_pulse_d = 1'b0;
    grant_found  = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d    = S_READY;
          cnt_d      = '0;
          credit_d   = '1;
          score_d    = '0;
          new_best_d = 1'b0;
        end
      end
      S_READY: begin
        if (flap_edge) begin
          flap_pulse_d = 1'b1;
          state_d      = S_PLAY;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == READY_LAST) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        flap_pulse_d = flap_edge;
        // Death outranks any pass arriving in the same cycle.
        if ((|collide) || ground_hit) begin
          state_d = S_DYING;
          cnt_d   = '0;
          flash_d = 1'b0;
        end else begin
          credit_d = credit_q | wraps;
          for (int i = 0; i < NUM_BARS; i++) begin
            if (eligible[i] && !grant_found) begin
              grant_found = 1'b1;
              credit_d[i] = 1'b0;
            end
          end
          if (grant_found && (score_q < SCORE_MAX_V)) score_d = score_q + SCORE_W'(1);
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEATH_LAST) begin
            state_d = S_OVER;
            flash_d = 1'b0;
            if (score_q > best_q) begin
              best_d     = score_q;
              new_best_d = 1'b1;
            end
          end else if (cnt_inc[2:0] == 3'b000) begin
            flash_d = ~flash_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    scroll_d  = (state_d == S_PLAY);
    physics_d = (state_d == S_PLAY) || (state_d == S_DYING);
    lose_d    = (state_d == S_DYING) || (state_d == S_OVER);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      credit_q     <= '1;
      score_q      <= '0;
      best_q       <= '0;
      new_best_q   <= 1'b0;
      flash_q      <= 1'b0;
      flap_pulse_q <= 1'b0;
      scroll_q     <= 1'b0;
      physics_q    <= 1'b0;
      lose_q       <= 1'b0;
      start_prev_q <= 1'b1;
      flap_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      credit_q     <= credit_d;
      score_q      <= score_d;
      best_q       <= best_d;
      new_best_q   <= new_best_d;
      flash_q      <= flash_d;
      flap_pulse_q <= flap_pulse_d;
      scroll_q     <= scroll_d;
      physics_q    <= physics_d;
      lose_q       <= lose_d;
      start_prev_q <= start_prev_d;
      flap_prev_q  <= flap_prev_d;
    end
  end

  assign state      = state_q;
  assign scroll_en  = scroll_q;
  assign physics_en = physics_q;
  assign flap_pulse = flap_pulse_q;
  assign lose       = lose_q;
  assign flash      = flash_q;
  assign score      = score_q;
  assign best       = best_q;
  assign new_best   = new_best_q;

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for Flappy Bruin, running on the 25 MHz pixel clock alongside the renderer. It owns the round lifecycle: idle, ready, play, dying and game over. It gates bar scrolling and bird physics per state and edge-qualifies the start and flap buttons. It arbitrates per-bar collision, pass and wrap events into a single saturating score and a session high score. It replaces the ad-hoc lose/score logic in the renderer with one sequenced, registered source of truth.

## Interface
- NUM_BARS, 3, number of obstacle bars (event vector width)
- SCORE_W, 10, score/best width
- SCORE_MAX, 999, score saturation value
- READY_FRAMES, 90, frames spent in READY before auto-start
- DEATH_FRAMES, 60, frames spent in DYING before OVER
- clk_25MHz  in  1  sole clock
- reset  in  1  synchronous, active-high; all state cleared on the clock edge where sampled high
- frame_tick  in  1  one-cycle pulse per video frame (60 Hz)
- game_start  in  1  raw start button level
- flap  in  1  raw flap button level
- collide  in  NUM_BARS  level: bird overlaps bar i outside its gap
- ground_hit  in  1  level: bird at floor/ceiling limit
- passed  in  NUM_BARS  level: bird left edge beyond bar i, inside its gap
- wraps  in  NUM_BARS  one-cycle pulse: bar i respawned at right edge
- state  out  3  IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4
- scroll_en  out  1  bars advance
- physics_en  out  1  bird gravity active
- flap_pulse  out  1  one-cycle qualified flap
- lose  out  1  round lost
- flash  out  1  death blink, toggles every 8 frame_ticks in DYING
- score  out  SCORE_W  current round score
- best  out  SCORE_W  session high score
- new_best  out  1  level: best was raised by the last round

## Operation
- Edge detect: start_edge = game_start & ~start_prev, flap_edge likewise. The prev registers reset to 1, so a button held through reset does not produce an edge.
- IDLE: scroll_en=0, physics_en=0, lose=0. start_edge -> READY.
- On entering READY from any state: score=0, all credit[i]=1, new_best=0, lose=0, frame counter=0.
- READY: scroll_en=0, physics_en=0. flap_edge gives flap_pulse and -> PLAY. Otherwise the counter increments per frame_tick; when it reaches READY_FRAMES, -> PLAY.
- PLAY: scroll_en=1, physics_en=1, flap_edge gives flap_pulse.
- PLAY, death: any collide[i] or ground_hit -> DYING, lose=1, counter=0.
- PLAY, scoring: grant the lowest i with passed[i] & credit[i] & ~wraps[i], one grant per cycle. A grant clears credit[i] and gives score = min(score+1, SCORE_MAX). Remaining eligible bars are granted on following cycles.
- PLAY, wraps[i]: sets credit[i]=1 and suppresses a grant to bar i in that cycle.
- PLAY, priority: a death condition in the same cycle as an eligible pass wins; no increment.
- DYING: scroll_en=0, physics_en=1, flap ignored, lose=1, flash toggles every 8th frame_tick. At DEATH_FRAMES ticks -> OVER. In the same edge, if score > best then best=score and new_best=1.
- OVER: scroll_en=0, physics_en=0, lose=1, flash=0, score held. start_edge -> READY.
- start_edge in READY, PLAY or DYING is ignored.
- reset: state=IDLE, score=0, best=0, new_best=0, lose=0, flash=0, scroll_en=0, physics_en=0, flap_pulse=0, credit=all 1, counter=0. Reset wins over every other event in the same cycle.

## Timing
- All outputs are registered. A condition sampled at edge N is visible after edge N (cycle N+1).
- Button high first sampled at N gives flap_pulse high for exactly cycle N+1. The state change to PLAY from READY lands the same cycle.
- collide high at N in PLAY gives state=DYING and lose=1 at N+1. scroll_en drops at N+1.
- Score latency is 1 cycle per grant. k simultaneous eligible bars complete in k cycles.
- frame_tick and events are sampled every cycle. A frame_tick coinciding with a transition counts toward the new state's counter only if it is that state's first tick after entry; the entry cycle's tick is not counted.
- Counters are sized to hold max(READY_FRAMES, DEATH_FRAMES) without wrap.

## Test plan
- Reset with game_start held high for 5 cycles, then held high -> no start_edge, state stays 0. Release then press -> state=1 one cycle after press.
- READY, no flap, 90 frame_ticks -> state=2 after the 90th tick. Repeat with a flap pulse at tick 10 -> state=2 and flap_pulse=1 for exactly one cycle.
- PLAY, passed=3'b011 with credits armed -> score 0→1→2 on consecutive cycles. passed held 50 more cycles -> score stays 2. wraps[0] pulse then passed[0] -> score 3.
- PLAY with score=998: passed[2] and collide[1] in the same cycle -> state=3, lose=1, score 998. After 60 ticks -> state=4, best=998, new_best=1.
- Score at SCORE_MAX=999 with a further pass -> score stays 999.
- OVER, start_edge -> state=1, score=0, lose=0, best retained. Reset asserted mid-PLAY -> all outputs at reset values the next cycle, best=0.
